csr_trap_ctrl: RTL and testbench
================================

# csr_trap_ctrl

Sequencer and state owner for the machine-mode CSR file. It holds every M-mode CSR register and commits next-state values from the combinational CSR decoder on instruction writes. It sequences trap entry on exceptions and interrupts, and trap return on MRET, and it runs the mcycle/minstret counters. It sits between the core's commit stage, the CSR decoder and the fetch redirect path.

## Interface
Parameters:
- MTVEC_RESET, 32'h0000_0000, reset value of {mtvec_base, 2'b00}; bits [1:0] ignored

Ports (clk, reset first):
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- state_q  out  csr_state_t  current CSR registers, fed to the CSR decoder
- state_d  in  csr_state_t  decoder next-state values
- csr_we  in  1  committed CSR instruction write this cycle
- instr_retire  in  1  instruction retired this cycle
- exc_valid  in  1  synchronous exception at commit
- exc_cause  in  mcause_t  exception cause
- exc_pc  in  32  PC of faulting instruction
- exc_tval  in  32  trap value
- mret  in  1  MRET committed
- irq_boundary  in  1  core at instruction boundary; interrupt may be taken
- next_pc  in  32  PC of next instruction, used as mepc for interrupts
- mtip, msip, meip  in  1 each  raw interrupt pending lines
- redirect_valid  out  1  fetch redirect request
- redirect_pc  out  32  redirect target
- redirect_ready  in  1  fetch accepts redirect
- stall  out  1  core must not commit while high

## Operation
- The FSM has three states: RUN, TRAP_WAIT and RET_WAIT.
- Event priority in RUN, applied once per cycle: exception > mret > interrupt > csr_we. Only the winning event takes effect. A csr_we in the same cycle as a winning trap event is dropped.
- Interrupt taken when all of the following hold:
  - mie is set.
  - irq_boundary is high.
  - No exception or mret is present that cycle.
  - (meip&meie)|(msip&msie)|(mtip&mtie) is nonzero.
- Interrupt cause priority: MEI > MSI > MTI.
- Trap entry updates these registers, then the FSM moves to TRAP_WAIT:
  - mepc = {exc_pc[31:2], 2'b00} for an exception, or {next_pc[31:2], 2'b00} for an interrupt.
  - mcause = exc_cause, or MCAUSE_MEI/MSI/MTI for an interrupt.
  - mtval = exc_tval for an exception, 0 for an interrupt.
  - mpie = mie; mie = 0.
- MRET updates mie = mpie and mpie = 1, then the FSM moves to RET_WAIT.
- csr_we alone copies state_d into all registers.
- TRAP_WAIT drives redirect_pc = {mtvec_base, 2'b00}. RET_WAIT drives redirect_pc = mepc.
- In both WAIT states, redirect_valid = 1 and stall = 1. All commit-side inputs are ignored. The FSM returns to RUN on the cycle after redirect_valid & redirect_ready.
- Counters:
  - mcycle increments every cycle unless mcycle_inhibit is set, in all FSM states.
  - minstret increments on instr_retire unless minstret_inhibit is set.
  - Both counters are 64-bit and wrap silently.
  - A csr_we that changes a counter half takes the written value for that cycle; there is no increment in that cycle.

## Timing
- Reset values:
  - State: RUN.
  - Outputs: redirect_valid = 0, stall = 0, redirect_pc = 0.
  - Registers set to 0: mie, mpie, mtie, msie, meie, counters, inhibits, mscratch, mepc, mcause (32'h0), mtval.
  - mtvec_base = MTVEC_RESET[31:2].
- An event sampled in cycle N updates the registers at the N/N+1 edge. redirect_valid and stall are high from N+1.
- redirect_valid is held until accepted, with a constant redirect_pc. Minimum trap-to-RUN time is 2 cycles when redirect_ready is already high.
- Reset asserted during a WAIT state: RUN is entered at the next edge and redirect_valid is low in the following cycle. No half-updated state survives.
- An interrupt line that drops before the boundary is not taken. There is no latching of pending bits.

## Configuration
- CSR_COUNTERS_EN defined: mcycle and minstret operate as described above.
- CSR_COUNTERS_EN undefined: both counters and both inhibit bits are tied to 0 in state_q, and writes to them are discarded. The counter sub-modules are not instantiated.

## Structure
- Package enums gains:
  - csr_state_t: packed struct of all registers listed above.
  - trap_fsm_t: RUN, TRAP_WAIT, RET_WAIT.
- mcause_t and its MCAUSE_* values remain in enums.
- Sub-module csr_counter: 64-bit counter with inhibit, increment enable and a split lo/hi write port. It is instantiated twice, for mcycle and minstret.

## Test plan
- Reset, then 10 idle cycles -> mcycle = 10, minstret = 0, redirect_valid = 0, mtvec = MTVEC_RESET.
- exc_valid with exc_cause = MCAUSE_ILLEGAL_INSTR, exc_pc = 32'h0000_0106, exc_tval = 32'hDEAD_BEEF, mie = 1 -> next cycle: mepc = 32'h0000_0104, mcause = ILLEGAL_INSTR, mtval = 32'hDEAD_BEEF, mpie = 1, mie = 0, redirect_pc = mtvec. Hold redirect_ready low for 3 cycles -> redirect_pc stays constant and stall stays high.
- meip, msip and mtip all pending and enabled, mie = 1, irq_boundary = 1, next_pc = 32'h200 -> mcause = MCAUSE_MEI, mepc = 32'h200, mtval = 0.
- exc_valid, mret and csr_we in the same cycle -> only the exception is applied; state_d is discarded.
- Write mcycle low half = 32'hFFFF_FFFF and high half = 32'hFFFF_FFFF -> after two more cycles, mcycle has wrapped through 0 and reads 1. The increment is suppressed in each write cycle.
- After trap entry with mie = 1, MRET -> mie = 1, mpie = 1, redirect_pc = mepc. Assert reset during RET_WAIT -> RUN next cycle and all registers at reset values.

Source files
------------

// File: rtl/csr_trap_ctrl_pkg.sv
// Shared types for the machine-mode CSR file and its trap sequencer:
// the mcause encodings, the trap FSM states, the packed register
// snapshot exchanged with the CSR decoder, and small helper functions.
package csr_trap_ctrl_pkg;

  // Architectural mcause values; bit 31 flags an interrupt
  typedef enum logic [31:0] {
    MCAUSE_INSTR_MISALIGNED = 32'h0000_0000,
    MCAUSE_INSTR_ACCESS     = 32'h0000_0001,
    MCAUSE_ILLEGAL_INSTR    = 32'h0000_0002,
    MCAUSE_BREAKPOINT       = 32'h0000_0003,
    MCAUSE_LOAD_MISALIGNED  = 32'h0000_0004,
    MCAUSE_LOAD_ACCESS      = 32'h0000_0005,
    MCAUSE_STORE_MISALIGNED = 32'h0000_0006,
    MCAUSE_STORE_ACCESS     = 32'h0000_0007,
    MCAUSE_ECALL_M          = 32'h0000_000B,
    MCAUSE_MSI              = 32'h8000_0003,
    MCAUSE_MTI              = 32'h8000_0007,
    MCAUSE_MEI              = 32'h8000_000B
  } mcause_t;

  // RUN commits normally; the WAIT states hold a redirect until fetch takes it
  typedef enum logic [1:0] {
    RUN       = 2'd0,
    TRAP_WAIT = 2'd1,
    RET_WAIT  = 2'd2
  } trap_fsm_t;

  // Every M-mode register owned by the trap controller
  typedef struct packed {
    logic        mie;
    logic        mpie;
    logic        mtie;
    logic        msie;
    logic        meie;
    logic [63:0] mcycle;
    logic [63:0] minstret;
    logic        mcycle_inhibit;
    logic        minstret_inhibit;
    logic [31:0] mscratch;
    logic [31:0] mepc;
    mcause_t     mcause;
    logic [31:0] mtval;
    logic [29:0] mtvec_base;
  } csr_state_t;

  localparam int unsigned CounterWidth = 64;

  // Clear the two low bits so mepc always holds a word-aligned address
  function automatic logic [31:0] alignPc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

  // Fixed interrupt priority: external, then software, then timer
  function automatic mcause_t irqCause(input logic [2:0] pending);
    if (pending[2]) begin
      return MCAUSE_MEI;
    end else if (pending[1]) begin
      return MCAUSE_MSI;
    end
    return MCAUSE_MTI;
  endfunction

  // Register contents right after reset; only mtvec has a non-zero value
  function automatic csr_state_t csrResetValue(input logic [31:0] mtvecReset);
    csr_state_t s;
    s            = '0;
    s.mtvec_base = mtvecReset[31:2];
    return s;
  endfunction

endpackage

// File: rtl/csr_trap_ctrl_counter.sv
// csr_counter: a 64-bit free-running event counter with an inhibit bit,
// an increment enable and independent writes of the low and high halves.
// A write to either half replaces the increment for that cycle, so the
// written value is exactly what software reads back afterwards.
module csr_counter
  import csr_trap_ctrl_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    inhibit_i,
  input  logic                    inc_i,
  input  logic                    we_lo_i,
  input  logic                    we_hi_i,
  input  logic [CounterWidth-1:0] wdata_i,
  output logic [CounterWidth-1:0] count_o
);

  logic [CounterWidth-1:0] count_q;
  logic [CounterWidth-1:0] count_d;

  // A half-write wins over counting; otherwise count when enabled and not inhibited
  always_comb begin
    count_d = count_q;
    if (we_lo_i || we_hi_i) begin
      if (we_lo_i) begin
        count_d[31:0] = wdata_i[31:0];
      end
      if (we_hi_i) begin
        count_d[63:32] = wdata_i[63:32];
      end
    end else if (inc_i && !inhibit_i) begin
      count_d = count_q + 64'd1;
    end
  end

  // Counter register, cleared by the synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/csr_trap_ctrl.sv
// csr_trap_ctrl: owner of the machine-mode CSR registers. Commits decoder
// writes, sequences trap entry (exceptions and interrupts) and MRET, and
// holds the fetch redirect until it is accepted.
// Optional feature macro: CSR_COUNTERS_EN enables mcycle/minstret; without
// it the counters and their inhibit bits read as zero and ignore writes.
module csr_trap_ctrl
  import csr_trap_ctrl_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output csr_state_t  state_q,
  input  csr_state_t  state_d,
  input  logic        csr_we,
  input  logic        instr_retire,
  input  logic        exc_valid,
  input  mcause_t     exc_cause,
  input  logic [31:0] exc_pc,
  input  logic [31:0] exc_tval,
  input  logic        mret,
  input  logic        irq_boundary,
  input  logic [31:0] next_pc,
  input  logic        mtip,
  input  logic        msip,
  input  logic        meip,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready,
  output logic        stall
);

  trap_fsm_t  fsm_q;
  trap_fsm_t  fsm_d;
  csr_state_t csrRegs_q;
  csr_state_t csrRegs_d;
  logic       csrAccept;
  logic       retireEn;
  logic [2:0] irqPending;

  // Resolve the single winning event in RUN and wait for the redirect handshake otherwise
  always_comb begin
    fsm_d      = fsm_q;
    csrRegs_d  = csrRegs_q;
    csrAccept  = 1'b0;
    retireEn   = 1'b0;
    irqPending = {meip & csrRegs_q.meie, msip & csrRegs_q.msie, mtip & csrRegs_q.mtie};
    case (fsm_q)
      RUN: begin
        retireEn = instr_retire;
        if (exc_valid) begin
          csrRegs_d.mepc   = alignPc(exc_pc);
          csrRegs_d.mcause = exc_cause;
          csrRegs_d.mtval  = exc_tval;
          csrRegs_d.mpie   = csrRegs_q.mie;
          csrRegs_d.mie    = 1'b0;
          fsm_d            = TRAP_WAIT;
        end else if (mret) begin
          csrRegs_d.mie  = csrRegs_q.mpie;
          csrRegs_d.mpie = 1'b1;
          fsm_d          = RET_WAIT;
        end else if (csrRegs_q.mie && irq_boundary && (irqPending != 3'b000)) begin
          csrRegs_d.mepc   = alignPc(next_pc);
          csrRegs_d.mcause = irqCause(irqPending);
          csrRegs_d.mtval  = 32'h0;
          csrRegs_d.mpie   = csrRegs_q.mie;
          csrRegs_d.mie    = 1'b0;
          fsm_d            = TRAP_WAIT;
        end else if (csr_we) begin
          csrRegs_d = state_d;
          csrAccept = 1'b1;
        end
      end
      TRAP_WAIT, RET_WAIT: begin
        if (redirect_ready) begin
          fsm_d = RUN;
        end
      end
      default: begin
        fsm_d = RUN;
      end
    endcase
    csrRegs_d.mcycle   = '0;
    csrRegs_d.minstret = '0;
`ifndef CSR_COUNTERS_EN
    csrRegs_d.mcycle_inhibit   = 1'b0;
    csrRegs_d.minstret_inhibit = 1'b0;
`endif
  end

  // FSM and CSR registers; reset drops any in-flight trap or return
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q     <= RUN;
      csrRegs_q <= csrResetValue(MTVEC_RESET);
    end else begin
      fsm_q     <= fsm_d;
      csrRegs_q <= csrRegs_d;
    end
  end

  // Redirect target and stall follow the WAIT state directly
  always_comb begin
    redirect_valid = 1'b0;
    stall          = 1'b0;
    redirect_pc    = 32'h0;
    case (fsm_q)
      TRAP_WAIT: begin
        redirect_valid = 1'b1;
        stall          = 1'b1;
        redirect_pc    = {csrRegs_q.mtvec_base, 2'b00};
      end
      RET_WAIT: begin
        redirect_valid = 1'b1;
        stall          = 1'b1;
        redirect_pc    = csrRegs_q.mepc;
      end
      default: begin
        redirect_valid = 1'b0;
      end
    endcase
  end

`ifdef CSR_COUNTERS_EN
  logic [63:0] mcycleCount;
  logic [63:0] minstretCount;
  logic        mcycleWeLo;
  logic        mcycleWeHi;
  logic        minstretWeLo;
  logic        minstretWeHi;

  assign mcycleWeLo   = csrAccept && (state_d.mcycle[31:0]    != mcycleCount[31:0]);
  assign mcycleWeHi   = csrAccept && (state_d.mcycle[63:32]   != mcycleCount[63:32]);
  assign minstretWeLo = csrAccept && (state_d.minstret[31:0]  != minstretCount[31:0]);
  assign minstretWeHi = csrAccept && (state_d.minstret[63:32] != minstretCount[63:32]);

  csr_counter u_mcycle (
    .clk       (clk),
    .reset     (reset),
    .inhibit_i (csrRegs_q.mcycle_inhibit),
    .inc_i     (1'b1),
    .we_lo_i   (mcycleWeLo),
    .we_hi_i   (mcycleWeHi),
    .wdata_i   (state_d.mcycle),
    .count_o   (mcycleCount)
  );

  csr_counter u_minstret (
    .clk       (clk),
    .reset     (reset),
    .inhibit_i (csrRegs_q.minstret_inhibit),
    .inc_i     (retireEn),
    .we_lo_i   (minstretWeLo),
    .we_hi_i   (minstretWeHi),
    .wdata_i   (state_d.minstret),
    .count_o   (minstretCount)
  );

  // Present the register snapshot with live counter values spliced in
  always_comb begin
    state_q          = csrRegs_q;
    state_q.mcycle   = mcycleCount;
    state_q.minstret = minstretCount;
  end
`else
  logic unusedCounterCtrl;

  assign unusedCounterCtrl = ^{csrAccept, retireEn};

  // Present the register snapshot with the counter fields hard-wired to zero
  always_comb begin
    state_q                  = csrRegs_q;
    state_q.mcycle           = '0;
    state_q.minstret         = '0;
    state_q.mcycle_inhibit   = 1'b0;
    state_q.minstret_inhibit = 1'b0;
  end
`endif

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// tb_csr_trap_ctrl: directed trap/return/counter scenarios followed by a
// randomized run, all compared against a behavioural model of the CSR file.
// Honours CSR_COUNTERS_EN the same way the design does.
module tb_csr_trap_ctrl;
  import csr_trap_ctrl_pkg::*;

  localparam logic [31:0] MtvecReset = 32'h0000_1003;
`ifdef CSR_COUNTERS_EN
  localparam bit CountersEn = 1'b1;
`else
  localparam bit CountersEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  csr_state_t  state_q;
  csr_state_t  state_d;
  logic        csr_we;
  logic        instr_retire;
  logic        exc_valid;
  mcause_t     exc_cause;
  logic [31:0] exc_pc;
  logic [31:0] exc_tval;
  logic        mret;
  logic        irq_boundary;
  logic [31:0] next_pc;
  logic        mtip;
  logic        msip;
  logic        meip;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;
  logic        stall;

  int checks = 0;
  int passes = 0;

  csr_state_t  expState;
  bit          expWaiting;
  logic [31:0] expTarget;
  csr_state_t  nxtState;
  bit          nxtWaiting;
  logic [31:0] nxtTarget;

  csr_trap_ctrl #(.MTVEC_RESET(MtvecReset)) dut (
    .clk            (clk),
    .reset          (reset),
    .state_q        (state_q),
    .state_d        (state_d),
    .csr_we         (csr_we),
    .instr_retire   (instr_retire),
    .exc_valid      (exc_valid),
    .exc_cause      (exc_cause),
    .exc_pc         (exc_pc),
    .exc_tval       (exc_tval),
    .mret           (mret),
    .irq_boundary   (irq_boundary),
    .next_pc        (next_pc),
    .mtip           (mtip),
    .msip           (msip),
    .meip           (meip),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .redirect_ready (redirect_ready),
    .stall          (stall)
  );

  // Free-running core clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed === expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  function automatic bit coin(input int unsigned pct);
    return $urandom_range(0, 99) < pct;
  endfunction

  function automatic csr_state_t resetValues();
    csr_state_t s;
    s            = '0;
    s.mtvec_base = MtvecReset[31:2];
    return s;
  endfunction

  task automatic clearInputs();
    csr_we         = 1'b0;
    instr_retire   = 1'b0;
    exc_valid      = 1'b0;
    exc_cause      = MCAUSE_INSTR_MISALIGNED;
    exc_pc         = 32'h0;
    exc_tval       = 32'h0;
    mret           = 1'b0;
    irq_boundary   = 1'b0;
    next_pc        = 32'h0;
    mtip           = 1'b0;
    msip           = 1'b0;
    meip           = 1'b0;
    redirect_ready = 1'b0;
    state_d        = expState;
  endtask

  // Apply the trap/return/write rules to the current inputs
  task automatic modelStep();
    bit accepted;
    bit retired;
    accepted   = 1'b0;
    retired    = 1'b0;
    nxtState   = expState;
    nxtWaiting = expWaiting;
    nxtTarget  = expTarget;
    if (reset) begin
      nxtState   = resetValues();
      nxtWaiting = 1'b0;
      nxtTarget  = 32'h0;
      return;
    end
    if (expWaiting) begin
      if (redirect_ready) nxtWaiting = 1'b0;
    end else begin
      retired = instr_retire;
      if (exc_valid) begin
        nxtState.mepc   = exc_pc & 32'hFFFF_FFFC;
        nxtState.mcause = exc_cause;
        nxtState.mtval  = exc_tval;
        nxtState.mpie   = expState.mie;
        nxtState.mie    = 1'b0;
        nxtWaiting      = 1'b1;
        nxtTarget       = {expState.mtvec_base, 2'b00};
      end else if (mret) begin
        nxtState.mie  = expState.mpie;
        nxtState.mpie = 1'b1;
        nxtWaiting    = 1'b1;
        nxtTarget     = expState.mepc;
      end else if (expState.mie && irq_boundary &&
                   ((meip && expState.meie) || (msip && expState.msie) || (mtip && expState.mtie))) begin
        if (meip && expState.meie)      nxtState.mcause = MCAUSE_MEI;
        else if (msip && expState.msie) nxtState.mcause = MCAUSE_MSI;
        else                            nxtState.mcause = MCAUSE_MTI;
        nxtState.mepc  = next_pc & 32'hFFFF_FFFC;
        nxtState.mtval = 32'h0;
        nxtState.mpie  = expState.mie;
        nxtState.mie   = 1'b0;
        nxtWaiting     = 1'b1;
        nxtTarget      = {expState.mtvec_base, 2'b00};
      end else if (csr_we) begin
        nxtState = state_d;
        accepted = 1'b1;
      end
    end
    if (CountersEn) begin
      if (accepted && (state_d.mcycle != expState.mcycle))
        nxtState.mcycle = state_d.mcycle;
      else
        nxtState.mcycle = expState.mcycle + (expState.mcycle_inhibit ? 64'd0 : 64'd1);
      if (accepted && (state_d.minstret != expState.minstret))
        nxtState.minstret = state_d.minstret;
      else
        nxtState.minstret = expState.minstret + ((retired && !expState.minstret_inhibit) ? 64'd1 : 64'd0);
    end else begin
      nxtState.mcycle           = 64'd0;
      nxtState.minstret         = 64'd0;
      nxtState.mcycle_inhibit   = 1'b0;
      nxtState.minstret_inhibit = 1'b0;
    end
  endtask

  task automatic checkAll();
    checkOutput("redirect_valid", 64'(redirect_valid), 64'(expWaiting));
    checkOutput("stall", 64'(stall), 64'(expWaiting));
    checkOutput("redirect_pc", 64'(redirect_pc), 64'(expWaiting ? expTarget : 32'h0));
    checkOutput("ie_bits", 64'({state_q.mie, state_q.mpie, state_q.mtie, state_q.msie, state_q.meie}),
                64'({expState.mie, expState.mpie, expState.mtie, expState.msie, expState.meie}));
    checkOutput("mcycle", state_q.mcycle, expState.mcycle);
    checkOutput("minstret", state_q.minstret, expState.minstret);
    checkOutput("inhibits", 64'({state_q.mcycle_inhibit, state_q.minstret_inhibit}),
                64'({expState.mcycle_inhibit, expState.minstret_inhibit}));
    checkOutput("mscratch", 64'(state_q.mscratch), 64'(expState.mscratch));
    checkOutput("mepc", 64'(state_q.mepc), 64'(expState.mepc));
    checkOutput("mcause", 64'(state_q.mcause), 64'(expState.mcause));
    checkOutput("mtval", 64'(state_q.mtval), 64'(expState.mtval));
    checkOutput("mtvec", 64'({state_q.mtvec_base, 2'b00}), 64'({expState.mtvec_base, 2'b00}));
  endtask

  // One clock: predict, advance the DUT, then compare away from the edge
  task automatic stepCycle();
    modelStep();
    @(posedge clk);
    #1;
    expState   = nxtState;
    expWaiting = nxtWaiting;
    expTarget  = nxtTarget;
    checkAll();
  endtask

  task automatic applyStimulus();
    clearInputs();
    reset          = coin(2);
    instr_retire   = coin(50);
    exc_valid      = coin(10);
    mret           = coin(10);
    csr_we         = coin(45);
    irq_boundary   = coin(50);
    meip           = coin(25);
    msip           = coin(25);
    mtip           = coin(25);
    redirect_ready = coin(50);
    exc_pc         = $urandom;
    exc_tval       = $urandom;
    next_pc        = $urandom;
    case ($urandom_range(0, 3))
      0:       exc_cause = MCAUSE_ILLEGAL_INSTR;
      1:       exc_cause = MCAUSE_ECALL_M;
      2:       exc_cause = MCAUSE_LOAD_ACCESS;
      default: exc_cause = MCAUSE_BREAKPOINT;
    endcase
    if (coin(50)) {state_d.mie, state_d.mpie, state_d.mtie, state_d.msie, state_d.meie} = 5'($urandom);
    if (coin(30)) state_d.mscratch = $urandom;
    if (coin(20)) state_d.mepc = $urandom;
    if (coin(20)) state_d.mtval = $urandom;
    if (coin(10)) state_d.mcause = mcause_t'($urandom);
    if (coin(10)) state_d.mtvec_base = 30'($urandom);
    if (coin(10)) state_d.mcycle_inhibit = coin(50);
    if (coin(10)) state_d.minstret_inhibit = coin(50);
    case ($urandom_range(0, 9))
      0:       state_d.mcycle[31:0]    = $urandom;
      1:       state_d.mcycle[63:32]   = $urandom;
      2:       state_d.minstret[31:0]  = $urandom;
      3:       state_d.minstret[63:32] = $urandom;
      4:       state_d.mcycle          = 64'hFFFF_FFFF_FFFF_FFFE;
      5:       state_d.minstret        = 64'hFFFF_FFFF_FFFF_FFFF;
      default: state_d.mscratch        = state_d.mscratch;
    endcase
  endtask

  initial begin
    reset    = 1'b1;
    expState = resetValues();
    expWaiting = 1'b0;
    expTarget  = 32'h0;
    clearInputs();
    stepCycle();
    checkOutput("reset_redirect_pc", 64'(redirect_pc), 64'h0);

    // Ten idle cycles after reset
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      clearInputs();
      stepCycle();
    end
    checkOutput("idle_mcycle", state_q.mcycle, CountersEn ? 64'd10 : 64'd0);
    checkOutput("idle_minstret", state_q.minstret, 64'd0);
    checkOutput("idle_redirect_valid", 64'(redirect_valid), 64'd0);
    checkOutput("idle_mtvec", 64'({state_q.mtvec_base, 2'b00}), 64'h1000);

    // Enable machine interrupts globally
    clearInputs();
    csr_we        = 1'b1;
    state_d.mie   = 1'b1;
    stepCycle();

    // Exception, MRET and CSR write together: only the exception lands
    clearInputs();
    exc_valid        = 1'b1;
    exc_cause        = MCAUSE_ILLEGAL_INSTR;
    exc_pc           = 32'h0000_0106;
    exc_tval         = 32'hDEAD_BEEF;
    mret             = 1'b1;
    csr_we           = 1'b1;
    state_d.mscratch = 32'h1234_5678;
    stepCycle();
    checkOutput("exc_mepc", 64'(state_q.mepc), 64'h104);
    checkOutput("exc_mcause", 64'(state_q.mcause), 64'(MCAUSE_ILLEGAL_INSTR));
    checkOutput("exc_mtval", 64'(state_q.mtval), 64'hDEAD_BEEF);
    checkOutput("exc_mpie_mie", 64'({state_q.mpie, state_q.mie}), 64'b10);
    checkOutput("exc_mscratch_dropped", 64'(state_q.mscratch), 64'h0);
    for (int i = 0; i < 3; i++) begin
      clearInputs();
      exc_valid = 1'b1;
      stepCycle();
      checkOutput("hold_redirect_pc", 64'(redirect_pc), 64'h1000);
      checkOutput("hold_stall", 64'(stall), 64'd1);
    end
    clearInputs();
    redirect_ready = 1'b1;
    stepCycle();
    checkOutput("exc_back_to_run", 64'(redirect_valid), 64'd0);

    // All three interrupts pending and enabled: external wins
    clearInputs();
    csr_we       = 1'b1;
    state_d.mie  = 1'b1;
    state_d.meie = 1'b1;
    state_d.msie = 1'b1;
    state_d.mtie = 1'b1;
    stepCycle();
    clearInputs();
    meip         = 1'b1;
    msip         = 1'b1;
    mtip         = 1'b1;
    irq_boundary = 1'b1;
    next_pc      = 32'h0000_0200;
    stepCycle();
    checkOutput("irq_mcause", 64'(state_q.mcause), 64'(MCAUSE_MEI));
    checkOutput("irq_mepc", 64'(state_q.mepc), 64'h200);
    checkOutput("irq_mtval", 64'(state_q.mtval), 64'h0);
    clearInputs();
    redirect_ready = 1'b1;
    stepCycle();

    // MRET restores mie, then reset lands in the middle of the return
    clearInputs();
    mret = 1'b1;
    stepCycle();
    checkOutput("mret_mie_mpie", 64'({state_q.mie, state_q.mpie}), 64'b11);
    checkOutput("mret_redirect_pc", 64'(redirect_pc), 64'h200);
    clearInputs();
    reset = 1'b1;
    stepCycle();
    checkOutput("ret_reset_valid", 64'(redirect_valid), 64'd0);
    checkOutput("ret_reset_mepc", 64'(state_q.mepc), 64'h0);
    reset = 1'b0;

    // Counter half writes followed by a wrap through zero
    clearInputs();
    csr_we               = 1'b1;
    state_d.mcycle[31:0] = 32'hFFFF_FFFF;
    stepCycle();
    clearInputs();
    csr_we                = 1'b1;
    state_d.mcycle[63:32] = 32'hFFFF_FFFF;
    stepCycle();
    checkOutput("wrap_written", state_q.mcycle, CountersEn ? 64'hFFFF_FFFF_FFFF_FFFF : 64'd0);
    for (int i = 0; i < 2; i++) begin
      clearInputs();
      stepCycle();
    end
    checkOutput("wrap_mcycle", state_q.mcycle, CountersEn ? 64'd1 : 64'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      applyStimulus();
      stepCycle();
    end

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
